rom_coef_arbiter: RTL

Round-robin arbiter and read sequencer that shares one synchronous coefficient ROM bank between several DDS polynomial datapath channels, such as the sine and cosine evaluation paths. It accepts per-channel read requests and issues at most one ROM read per cycle. It tracks the one-cycle ROM read latency and returns each coefficient word to the channel that requested it. It sits between the channel sequencers and the ROM_memA* coefficient memories. All ROMs in a bank share `rom_en` and `rom_addr`.

---
 rtl/rom_coef_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rom_coef_arbiter.sv
// rom_coef_arbiter: shares one synchronous coefficient ROM bank between
// NUM_REQ datapath channels. Accepts at most one read per cycle (round-robin
// or fixed priority), tracks the one-cycle ROM latency with a two-stage tag
// pipeline and returns each word to the channel that requested it.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   prio_mode    0 = round-robin, 1 = fixed priority (lowest index wins)
//   req          per-channel level-sensitive read request
//   req_addr     channel i address in [i*ADDR_WIDTH +: ADDR_WIDTH]
//   gnt          registered one-hot acceptance pulse
//   rom_en       registered ROM read enable
//   rom_addr     registered ROM address
//   rom_data     ROM registered output (valid one cycle after rom_en)
//   rsp_valid    registered one-hot pulse: rsp_data belongs to channel i
//   rsp_data     registered coefficient word
module rom_coef_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prio_mode,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          rom_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [IDX_W-1:0]      last;
    tag_t                  tag_s1;
    tag_t                  tag_s2;

    logic                  any_req;
    logic                  hi_found;
    logic [IDX_W-1:0]      hi_idx;
    logic [IDX_W-1:0]      lo_idx;
    logic [IDX_W-1:0]      win_idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [NUM_REQ-1:0]    gnt_nxt;
    logic [NUM_REQ-1:0]    rsp_nxt;

    // Winner selection. lo_idx is the lowest set request (fixed-priority
    // winner and round-robin wrap-around); hi_idx is the lowest set request
    // above the last winner (round-robin without wrap).
    always_comb begin
        any_req  = |req;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) > last) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        if (prio_mode) begin
            win_idx = lo_idx;
        end else begin
            win_idx = hi_found ? hi_idx : lo_idx;
        end
    end

    // Winner address mux and one-hot decodes for grant and response.
    always_comb begin
        win_addr = '0;
        gnt_nxt  = '0;
        rsp_nxt  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_nxt[i] = any_req;
            end
            if (IDX_W'(i) == tag_s2.idx) begin
                rsp_nxt[i] = tag_s2.vld;
            end
        end
    end

    // Grant issue, tag pipeline and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
            tag_s1    <= '0;
            tag_s2    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            gnt        <= gnt_nxt;
            rom_en     <= any_req;
            tag_s1.vld <= any_req;
            tag_s1.idx <= win_idx;
            if (any_req) begin
                rom_addr <= win_addr;
                last     <= win_idx;
            end
            tag_s2    <= tag_s1;
            rsp_valid <= rsp_nxt;
            // rom_data is only meaningful when the stage-2 tag is valid.
            if (tag_s2.vld) begin
                rsp_data <= rom_data;
            end
        end
    end

endmodule
